// File: rtl/gpr_file_sb.sv
// gpr_file_sb: 2**ADDR_W x DATA_W register file, two async read ports,
// one sync write port and a per-register pending-bit scoreboard.
// Ports: clk, rst_n (async low); wr_en/wr_addr/wr_data write-back;
//   rd_addr_n -> rd_data_n, rd_busy_n (combinational), n = 1,2;
//   sb_set_en/sb_set_addr issue, sb_flush clear-all; busy_count (registered).
// Option: define GPR_BYPASS_EN for write-to-read forwarding.
module gpr_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_1,
   output logic [DATA_W-1:0] rd_data_1,
   output logic              rd_busy_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic [DATA_W-1:0] rd_data_2,
   output logic              rd_busy_2,
   input  logic              sb_set_en,
   input  logic [ADDR_W-1:0] sb_set_addr,
   input  logic              sb_flush,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]             busy_q, busy_d;
   logic [ADDR_W:0]              busy_count_q, busy_count_d;

   logic wr_ok;
   logic set_ok;

   // Address 0 is hardwired when ZERO_REG is set.
   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wr_ok  = wr_en && !is_zero(wr_addr);
   assign set_ok = sb_set_en && !is_zero(sb_set_addr);

   always_comb begin
      regs_d = regs_q;
      if (wr_ok)
         regs_d[wr_addr] = wr_data;
   end

   // Clear on write first, then set on issue, so a same-address
   // issue wins over the write-back; flush overrides both.
   always_comb begin
      busy_d = busy_q;
      if (sb_flush) begin
         busy_d = '0;
      end else begin
         if (wr_ok)
            busy_d[wr_addr] = 1'b0;
         if (set_ok)
            busy_d[sb_set_addr] = 1'b1;
      end
   end

   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q       <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   function automatic logic [DATA_W-1:0] rd_data_f(
      input logic [ADDR_W-1:0] a
   );
      logic [DATA_W-1:0] d;
      d = regs_q[a];
`ifdef GPR_BYPASS_EN
      if (wr_ok && (a == wr_addr))
         d = wr_data;
`endif
      if (is_zero(a))
         d = '0;
      return d;
   endfunction

   function automatic logic rd_busy_f(input logic [ADDR_W-1:0] a);
      logic b;
      b = busy_q[a];
`ifdef GPR_BYPASS_EN
      // A forwarded write retires the producer unless it is re-issued now.
      if (wr_ok && (a == wr_addr))
         b = busy_q[a] && sb_set_en && (sb_set_addr == wr_addr);
`endif
      if (is_zero(a))
         b = 1'b0;
      return b;
   endfunction

   assign rd_data_1  = rd_data_f(rd_addr_1);
   assign rd_busy_1  = rd_busy_f(rd_addr_1);
   assign rd_data_2  = rd_data_f(rd_addr_2);
   assign rd_busy_2  = rd_busy_f(rd_addr_2);
   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed + random check of gpr_file_sb against a
// behavioural model; instance a has ZERO_REG=0, instance b ZERO_REG=1.
module tb_gpr_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  rd_addr_1, rd_addr_2;
   logic        sb_set_en;
   logic [2:0]  sb_set_addr;
   logic        sb_flush;

   logic [15:0] rd_data_1_a, rd_data_2_a, rd_data_1_b, rd_data_2_b;
   logic        rd_busy_1_a, rd_busy_2_a, rd_busy_1_b, rd_busy_2_b;
   logic [3:0]  busy_count_a, busy_count_b;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_reg  [2][8];
   bit          m_busy [2][8];

   always #5 clk = ~clk;

   gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1_a),
      .rd_busy_1(rd_busy_1_a),
      .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2_a),
      .rd_busy_2(rd_busy_2_a),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
      .sb_flush(sb_flush), .busy_count(busy_count_a)
   );

   gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1_b),
      .rd_busy_1(rd_busy_1_b),
      .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2_b),
      .rd_busy_2(rd_busy_2_b),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
      .sb_flush(sb_flush), .busy_count(busy_count_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void m_reset();
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < 8; i++) begin
            m_reg[z][i]  = '0;
            m_busy[z][i] = 1'b0;
         end
   endfunction

   function automatic bit hard0(int z, int a);
      return (z == 1) && (a == 0);
   endfunction

   function automatic logic [15:0] m_data(int z, int a);
      if (hard0(z, a)) return 16'h0;
`ifdef GPR_BYPASS_EN
      if (wr_en && a == int'(wr_addr)) return wr_data;
`endif
      return m_reg[z][a];
   endfunction

   function automatic bit m_bsy(int z, int a);
      if (hard0(z, a)) return 1'b0;
`ifdef GPR_BYPASS_EN
      if (wr_en && a == int'(wr_addr))
         return m_busy[z][a] && sb_set_en && (sb_set_addr == wr_addr);
`endif
      return m_busy[z][a];
   endfunction

   function automatic int m_cnt(int z);
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(m_busy[z][i]);
      return c;
   endfunction

   function automatic void m_step();
      for (int z = 0; z < 2; z++) begin
         if (wr_en && !hard0(z, int'(wr_addr)))
            m_reg[z][wr_addr] = wr_data;
         if (sb_flush) begin
            for (int i = 0; i < 8; i++) m_busy[z][i] = 1'b0;
         end else begin
            if (wr_en && !hard0(z, int'(wr_addr)))
               m_busy[z][wr_addr] = 1'b0;
            if (sb_set_en && !hard0(z, int'(sb_set_addr)))
               m_busy[z][sb_set_addr] = 1'b1;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic check_all(input string tag);
      chk({tag, ".a.d1"}, 32'(rd_data_1_a), 32'(m_data(0, rd_addr_1)));
      chk({tag, ".a.d2"}, 32'(rd_data_2_a), 32'(m_data(0, rd_addr_2)));
      chk({tag, ".a.b1"}, 32'(rd_busy_1_a), 32'(m_bsy(0, rd_addr_1)));
      chk({tag, ".a.b2"}, 32'(rd_busy_2_a), 32'(m_bsy(0, rd_addr_2)));
      chk({tag, ".a.cnt"}, 32'(busy_count_a), 32'(m_cnt(0)));
      chk({tag, ".b.d1"}, 32'(rd_data_1_b), 32'(m_data(1, rd_addr_1)));
      chk({tag, ".b.d2"}, 32'(rd_data_2_b), 32'(m_data(1, rd_addr_2)));
      chk({tag, ".b.b1"}, 32'(rd_busy_1_b), 32'(m_bsy(1, rd_addr_1)));
      chk({tag, ".b.b2"}, 32'(rd_busy_2_b), 32'(m_bsy(1, rd_addr_2)));
      chk({tag, ".b.cnt"}, 32'(busy_count_b), 32'(m_cnt(1)));
   endtask

   task automatic apply(input string tag, input logic we,
                        input logic [2:0] wa, input logic [15:0] wd,
                        input logic se, input logic [2:0] sa,
                        input logic fl, input logic [2:0] r1,
                        input logic [2:0] r2);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      sb_set_en = se; sb_set_addr = sa; sb_flush = fl;
      rd_addr_1 = r1; rd_addr_2 = r2;
      #1;
      check_all(tag);
   endtask

   task automatic step();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic cyc(input string tag, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input logic se, input logic [2:0] sa,
                      input logic fl, input logic [2:0] r1,
                      input logic [2:0] r2);
      apply(tag, we, wa, wd, se, sa, fl, r1, r2);
      step();
   endtask

   task automatic look(input string tag, input logic [2:0] r1,
                       input logic [2:0] r2);
      apply(tag, 0, 0, 0, 0, 0, 0, r1, r2);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 0; wr_addr = 0; wr_data = 0;
      sb_set_en = 0; sb_set_addr = 0; sb_flush = 0;
      rd_addr_1 = 0; rd_addr_2 = 0;
      m_reset();
      #1;
      check_all("rst0");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-cycle, no write on a reset edge
      cyc("w3", 1, 3, 16'h1234, 0, 0, 0, 3, 5);
      cyc("s5", 0, 0, 0, 1, 5, 0, 3, 5);
      look("pre_rst", 3, 5);
      chk("pre_rst.r3", 32'(rd_data_1_a), 32'h1234);
      chk("pre_rst.b5", 32'(rd_busy_2_a), 32'h1);
      #2 rst_n = 1'b0;
      wr_en = 1; wr_addr = 3; wr_data = 16'h7777;
      #1;
      m_reset();
      chk("rst.r3", 32'(rd_data_1_a), 32'h0);
      chk("rst.b5", 32'(rd_busy_2_a), 32'h0);
      chk("rst.cnt", 32'(busy_count_a), 32'h0);
      @(posedge clk);
      @(negedge clk);
      wr_en = 0;
      rst_n = 1'b1;
      #1;
      chk("rst_nowr.r3", 32'(rd_data_1_a), 32'h0);

      // write / read
      cyc("w2", 1, 2, 16'hBEEF, 0, 0, 0, 2, 7);
      cyc("w7", 1, 7, 16'h00FF, 0, 0, 0, 2, 7);
      look("rd27", 2, 7);
      chk("rd.r2", 32'(rd_data_1_a), 32'hBEEF);
      chk("rd.r7", 32'(rd_data_2_a), 32'h00FF);

      // scoreboard
      cyc("s4", 0, 0, 0, 1, 4, 0, 4, 6);
      look("c1", 4, 6);
      chk("sb.cnt1", 32'(busy_count_a), 32'd1);
      cyc("s6", 0, 0, 0, 1, 6, 0, 4, 6);
      look("c2", 4, 6);
      chk("sb.cnt2", 32'(busy_count_a), 32'd2);
      cyc("w4", 1, 4, 16'h0044, 0, 0, 0, 4, 6);
      look("c3", 4, 6);
      chk("sb.b4", 32'(rd_busy_1_a), 32'h0);
      chk("sb.cnt3", 32'(busy_count_a), 32'd1);
      cyc("sw6", 1, 6, 16'h0066, 1, 6, 0, 4, 6);
      look("c4", 6, 4);
      chk("sb.b6", 32'(rd_busy_1_a), 32'h1);
      chk("sb.cnt4", 32'(busy_count_a), 32'd1);

      // flush
      cyc("s1", 0, 0, 0, 1, 1, 0, 1, 2);
      cyc("s2", 0, 0, 0, 1, 2, 0, 1, 2);
      cyc("s3", 0, 0, 0, 1, 3, 0, 1, 3);
      cyc("fl", 1, 1, 16'h0042, 1, 5, 1, 1, 5);
      look("fl_chk", 1, 5);
      chk("fl.cnt", 32'(busy_count_a), 32'd0);
      chk("fl.b5", 32'(rd_busy_2_a), 32'h0);
      chk("fl.r1", 32'(rd_data_1_a), 32'h0042);

      // register 0
      cyc("z0", 1, 0, 16'hFFFF, 1, 0, 0, 0, 0);
      look("z0_chk", 0, 0);
      chk("z0.a.d", 32'(rd_data_1_a), 32'hFFFF);
      chk("z0.b.d", 32'(rd_data_1_b), 32'h0);
      chk("z0.b.b", 32'(rd_busy_1_b), 32'h0);
      chk("z0.b.cnt", 32'(busy_count_b), 32'd0);

      // write-to-read forwarding
      cyc("s3b", 0, 0, 0, 1, 3, 0, 3, 3);
      apply("byp", 1, 3, 16'hA5A5, 0, 0, 0, 3, 2);
`ifdef GPR_BYPASS_EN
      chk("byp.d", 32'(rd_data_1_a), 32'hA5A5);
      chk("byp.b", 32'(rd_busy_1_a), 32'h0);
`else
      chk("byp.d", 32'(rd_data_1_a), 32'h0);
      chk("byp.b", 32'(rd_busy_1_a), 32'h1);
`endif
      step();

      // random
      for (int n = 0; n < 500; n++) begin
         logic [2:0] wa, r1;
         wa = 3'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
         cyc("rnd", 1'($urandom_range(0, 1)), wa, 16'($urandom),
             1'($urandom_range(0, 4) < 2), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 15) == 0), r1,
             3'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with two asynchronous read ports, one synchronous write port and an integrated scoreboard of per-register pending bits. It is the next-generation GPR block in the RISC datapath: the decode stage reads operands and marks destination registers pending at issue, and the write-back stage clears them. Width, depth and zero-register behaviour are parameters. Write-to-read forwarding is a compile-time option.

## Interface
- `DATA_W`, default 16: register width in bits.
- `ADDR_W`, default 3: address width; depth = 2**ADDR_W.
- `ZERO_REG`, default 0:
  - 1 = register 0 always reads 0, ignores writes and is never busy.
  - 0 = register 0 is an ordinary register.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write-back enable.
- `wr_addr`  in  ADDR_W  write-back destination.
- `wr_data`  in  DATA_W  write-back data.
- `rd_addr_1`  in  ADDR_W  read port 1 address.
- `rd_data_1`  out  DATA_W  read port 1 data (combinational).
- `rd_busy_1`  out  1  pending bit of `rd_addr_1` (combinational).
- `rd_addr_2`  in  ADDR_W  read port 2 address.
- `rd_data_2`  out  DATA_W  read port 2 data (combinational).
- `rd_busy_2`  out  1  pending bit of `rd_addr_2` (combinational).
- `sb_set_en`  in  1  issue: mark `sb_set_addr` pending.
- `sb_set_addr`  in  ADDR_W  destination being issued.
- `sb_flush`  in  1  clear all pending bits (pipeline flush).
- `busy_count`  out  ADDR_W+1  registered count of pending registers.

## Operation
- **Storage:** 2**ADDR_W registers of DATA_W bits, plus one busy bit per register.
- **Reset** (`rst_n` low, asynchronous):
  - All registers, busy bits and `busy_count` go to 0 immediately.
  - Read data and busy outputs therefore read 0 while reset is held.
  - An operation in flight during reset is discarded; no write completes on the edge where `rst_n` is low.
- **Write:** when `wr_en` = 1 at a rising edge, `reg[wr_addr]` <= `wr_data`, and the busy bit of `wr_addr` is cleared.
- **Issue:** when `sb_set_en` = 1 at a rising edge, the busy bit of `sb_set_addr` is set.
- **Busy-bit priority**, per register, per edge (highest first):
  1. `sb_flush` clears every bit; `sb_set_en` is ignored that cycle.
  2. `sb_set_en` on the same address as `wr_en` leaves the bit set, because a new producer has been issued.
  3. `wr_en` clears the bit.
- **Data during flush:** `sb_flush` does not affect register data; a concurrent `wr_en` still writes.
- **ZERO_REG = 1, address 0:**
  - Writes are dropped.
  - `sb_set_en` is ignored.
  - Reads return 0 and busy returns 0.
- **Reads:** `rd_data_n` = `reg[rd_addr_n]` and `rd_busy_n` = `busy[rd_addr_n]`. Both ports are independent and may share an address.
- **busy_count:** popcount of the busy vector after the edge update, held in a register.
  - Range is 0 to 2**ADDR_W, so the width is ADDR_W+1 and it cannot overflow.

## Timing
- **Write latency:** data written at edge N is visible on the read ports from edge N onward, i.e. in cycle N+1 (without bypass).
- **Busy set:** a bit set at edge N reads 1 from edge N onward. `busy_count` reflects the change in the same cycle.
- **Reads:** purely combinational from address to data and busy; no clock latency.
- **Reset:** reset release is synchronous to the first rising edge with `rst_n` high; there is no extra idle cycle.

## Configuration
- **`GPR_BYPASS_EN` defined:** when `wr_en` = 1 and `rd_addr_n` == `wr_addr`, in the same cycle:
  - `rd_data_n` returns `wr_data`.
  - `rd_busy_n` returns `busy[rd_addr_n]` AND NOT(`sb_set_en` = 0 OR `sb_set_addr` != `wr_addr`), i.e. it shows 0 unless the same address is being re-issued this cycle.
  - With ZERO_REG = 1, address 0 is never bypassed.
  - Stored state and `busy_count` are unaffected.
- **`GPR_BYPASS_EN` undefined:** reads return stored state only; new data appears one cycle after the write edge.

## Test plan
- **Reset:** set r3=0x1234 and mark r5 busy; pulse `rst_n` low mid-cycle -> all reads return 0x0000, busy 0 and `busy_count` 0 immediately, without waiting for a clock edge.
- **Write/read:** write r2=0xBEEF and r7=0x00FF on consecutive edges; read with `rd_addr_1`=2 and `rd_addr_2`=7 -> 0xBEEF and 0x00FF.
  - Without bypass, reading r2 in the write cycle still returns the old value 0x0000.
- **Scoreboard:**
  - Issue r4, then r6 -> `busy_count` goes 1, then 2.
  - Write r4 -> `rd_busy` for r4 = 0 and `busy_count` = 1.
  - Issue and write r6 on the same edge -> r6 stays busy and `busy_count` stays 1.
- **Flush:** with r1, r2 and r3 busy, assert `sb_flush` together with `sb_set_en` on r5 and `wr_en` r1=0x0042 -> `busy_count` = 0, r5 not busy, r1 reads 0x0042.
- **ZERO_REG = 1:** write r0=0xFFFF and issue r0 -> r0 reads 0x0000, not busy, `busy_count` unchanged. With ZERO_REG = 0, the same stimulus reads 0xFFFF.
- **`GPR_BYPASS_EN`:** with r3 busy, `wr_en` r3=0xA5A5 and `rd_addr_1`=3 in the same cycle -> `rd_data_1` = 0xA5A5 and `rd_busy_1` = 0 before the edge.
